// File: rtl/ulpi_link_arbiter.sv
// ULPI link-side transmit arbiter: shares the PHY transmit path between a register
// port and a packet port, sequencing TXCMD/data/STP and forwarding RXCMD bytes.
module ulpi_link_arbiter #(
  parameter int NXT_TIMEOUT   = 1023,
  parameter bit RR_RESET_LAST = 1'b1
) (
  input  logic       CLKOUT,
  input  logic       RESET,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       STP,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_done,
  output logic [7:0] reg_rdata,
  input  logic       pkt_req,
  input  logic [3:0] pkt_pid,
  input  logic       pkt_nodata,
  input  logic [7:0] pkt_data,
  input  logic       pkt_valid,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic       pkt_done,
  output logic       pkt_abort,
  output logic       reg_abort,
  output logic [7:0] rxcmd,
  output logic       rxcmd_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, TXCMD, REG_WDATA, STOP, RD_TURN, RD_DATA, PKT_DATA, WAIT_DIR_LOW
  } state_t;

  localparam int TW = $clog2(NXT_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(NXT_TIMEOUT - 1);

  state_t        state;
  logic          dir_q;
  logic          last_grant;
  logic          is_pkt;
  logic          cmd_we;
  logic          nodata;
  logic          retry;
  logic [7:0]    cmd_byte;
  logic [TW-1:0] timer;
  logic          reg_wins;

  // dir_q high with DIR low marks the turnaround cycle after the PHY releases the bus
  assign data_oe   = !DIR && !dir_q;
  assign busy      = (state != IDLE);
  assign pkt_ready = (state == PKT_DATA) && NXT && pkt_valid && !DIR;
  assign reg_wins  = reg_req && (!pkt_req || last_grant);

  always_comb begin
    data_out = 8'h00;
    case (state)
      TXCMD:     data_out = cmd_byte;
      REG_WDATA: data_out = reg_wdata;
      PKT_DATA:  data_out = pkt_data;
      default:   data_out = 8'h00;
    endcase
  end

  always_ff @(posedge CLKOUT) begin
    if (RESET) begin
      state       <= IDLE;
      dir_q       <= 1'b0;
      last_grant  <= RR_RESET_LAST;
      is_pkt      <= 1'b0;
      cmd_we      <= 1'b0;
      nodata      <= 1'b0;
      retry       <= 1'b0;
      cmd_byte    <= 8'h00;
      timer       <= '0;
      STP         <= 1'b0;
      reg_done    <= 1'b0;
      reg_abort   <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_abort   <= 1'b0;
      reg_rdata   <= 8'h00;
      rxcmd       <= 8'h00;
      rxcmd_valid <= 1'b0;
    end else begin
      dir_q       <= DIR;
      STP         <= 1'b0;
      reg_done    <= 1'b0;
      reg_abort   <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_abort   <= 1'b0;
      rxcmd_valid <= 1'b0;

      // Register read data also arrives with DIR=1, NXT=0 and must not pose as an RXCMD
      if (DIR && dir_q && !NXT && state != RD_DATA) begin
        rxcmd       <= data_in;
        rxcmd_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!DIR && !dir_q && (reg_req || pkt_req)) begin
            state <= TXCMD;
            timer <= '0;
            retry <= 1'b0;
            if (reg_wins) begin
              is_pkt     <= 1'b0;
              cmd_we     <= reg_we;
              cmd_byte   <= {(reg_we ? 2'b10 : 2'b11), reg_addr};
              last_grant <= 1'b0;
            end else begin
              is_pkt     <= 1'b1;
              nodata     <= pkt_nodata;
              cmd_byte   <= {4'b0100, pkt_pid};
              last_grant <= 1'b1;
            end
          end
        end

        TXCMD: begin
          if (DIR) begin
            state     <= WAIT_DIR_LOW;
            retry     <= !is_pkt;
            pkt_abort <= is_pkt;
          end else if (NXT) begin
            if (is_pkt && nodata) begin
              state    <= STOP;
              STP      <= 1'b1;
              pkt_done <= 1'b1;
            end else if (is_pkt) begin
              state <= PKT_DATA;
            end else if (cmd_we) begin
              state <= REG_WDATA;
            end else begin
              state <= RD_TURN;
            end
          end else if (timer == T_LAST) begin
            state     <= IDLE;
            pkt_abort <= is_pkt;
            reg_abort <= !is_pkt;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        REG_WDATA: begin
          if (DIR) begin
            state <= WAIT_DIR_LOW;
            retry <= 1'b1;
          end else if (NXT) begin
            state    <= STOP;
            STP      <= 1'b1;
            reg_done <= 1'b1;
          end
        end

        STOP: state <= IDLE;

        RD_TURN: begin
          if (DIR) state <= RD_DATA;
        end

        RD_DATA: begin
          reg_rdata <= data_in;
          reg_done  <= 1'b1;
          retry     <= 1'b0;
          state     <= WAIT_DIR_LOW;
        end

        PKT_DATA: begin
          if (DIR) begin
            state     <= WAIT_DIR_LOW;
            retry     <= 1'b0;
            pkt_abort <= 1'b1;
          end else if (NXT && pkt_valid && pkt_last) begin
            state    <= STOP;
            STP      <= 1'b1;
            pkt_done <= 1'b1;
          end else if (NXT && !pkt_valid) begin
            state     <= STOP;
            STP       <= 1'b1;
            pkt_abort <= 1'b1;
          end
        end

        WAIT_DIR_LOW: begin
          // Leaving here at the end of the turnaround cycle keeps the link off the bus for it
          if (!DIR) begin
            state <= retry ? TXCMD : IDLE;
            timer <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_link_arbiter.sv
// Directed testbench for ulpi_link_arbiter: a hand-driven PHY model with per-scenario
// tasks, each comparing outputs against hand-computed values.
module tb_ulpi_link_arbiter;

  logic       CLKOUT = 1'b0;
  logic       RESET, DIR, NXT;
  logic [7:0] data_in, data_out;
  logic       data_oe, STP;
  logic       reg_req, reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_done, reg_abort;
  logic       pkt_req, pkt_nodata, pkt_valid, pkt_last;
  logic [3:0] pkt_pid;
  logic [7:0] pkt_data;
  logic       pkt_ready, pkt_done, pkt_abort;
  logic [7:0] rxcmd;
  logic       rxcmd_valid, busy;

  int checks = 0;
  int passes = 0;

  ulpi_link_arbiter dut (
    .CLKOUT(CLKOUT), .RESET(RESET), .DIR(DIR), .NXT(NXT), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .STP(STP),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_done(reg_done), .reg_rdata(reg_rdata),
    .pkt_req(pkt_req), .pkt_pid(pkt_pid), .pkt_nodata(pkt_nodata), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
    .pkt_done(pkt_done), .pkt_abort(pkt_abort), .reg_abort(reg_abort),
    .rxcmd(rxcmd), .rxcmd_valid(rxcmd_valid), .busy(busy)
  );

  always #5 CLKOUT = ~CLKOUT;

  // Inputs change on the falling edge; outputs are sampled 1 ns later
  task automatic test_reset();
    RESET = 1'b1; DIR = 1'b0; NXT = 1'b0; data_in = 8'h00;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = 6'h00; reg_wdata = 8'h00;
    pkt_req = 1'b0; pkt_pid = 4'h0; pkt_nodata = 1'b0; pkt_data = 8'h00;
    pkt_valid = 1'b0; pkt_last = 1'b0;
    repeat (2) @(negedge CLKOUT);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passes++;
    checks++; if (data_out !== 8'h00) $display("FAIL rst_data got=%h exp=00", data_out); else passes++;
    checks++; if (STP !== 1'b0) $display("FAIL rst_stp got=%b exp=0", STP); else passes++;
    checks++; if (data_oe !== 1'b1) $display("FAIL rst_oe got=%b exp=1", data_oe); else passes++;
    checks++; if ({reg_done, pkt_done, pkt_abort, reg_abort, rxcmd_valid} !== 5'b0)
      $display("FAIL rst_pulses got=%b exp=00000", {reg_done, pkt_done, pkt_abort, reg_abort, rxcmd_valid}); else passes++;
    checks++; if ({reg_rdata, rxcmd} !== 16'h0000) $display("FAIL rst_regs got=%h exp=0000", {reg_rdata, rxcmd}); else passes++;
    @(negedge CLKOUT); RESET = 1'b0;
  endtask

  task automatic test_reg_write();
    @(negedge CLKOUT); reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h0A; reg_wdata = 8'h00;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'h8A) $display("FAIL wr_cmd got=%h exp=8a", data_out); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL wr_busy got=%b exp=1", busy); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h8A) $display("FAIL wr_cmd_hold got=%h exp=8a", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (data_out !== 8'h00 || STP !== 1'b0) $display("FAIL wr_data got=%h/%b exp=00/0", data_out, STP); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (reg_done !== 1'b0) $display("FAIL wr_early_done got=%b exp=0", reg_done); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (STP !== 1'b1 || reg_done !== 1'b1 || data_out !== 8'h00)
      $display("FAIL wr_stop got=stp%b done%b data%h exp=stp1 done1 data00", STP, reg_done, data_out); else passes++;
    reg_req = 1'b0;
    @(negedge CLKOUT); #1;
    checks++; if (busy !== 1'b0 || STP !== 1'b0 || reg_done !== 1'b0)
      $display("FAIL wr_after got=busy%b stp%b done%b exp=000", busy, STP, reg_done); else passes++;
  endtask

  task automatic test_reg_read();
    @(negedge CLKOUT); reg_req = 1'b1; reg_we = 1'b0; reg_addr = 6'h00;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'hC0) $display("FAIL rd_cmd got=%h exp=c0", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'hC0) $display("FAIL rd_cmd_hold got=%h exp=c0", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; DIR = 1'b1; #1;
    checks++; if (data_oe !== 1'b0) $display("FAIL rd_turn_oe got=%b exp=0", data_oe); else passes++;
    @(negedge CLKOUT); data_in = 8'h24; #1;
    checks++; if (reg_done !== 1'b0 || data_oe !== 1'b0) $display("FAIL rd_data_cycle got=done%b oe%b exp=0/0", reg_done, data_oe); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (reg_done !== 1'b1 || reg_rdata !== 8'h24) $display("FAIL rd_result got=done%b rdata%h exp=1/24", reg_done, reg_rdata); else passes++;
    checks++; if (rxcmd_valid !== 1'b0) $display("FAIL rd_not_rxcmd got=%b exp=0", rxcmd_valid); else passes++;
    reg_req = 1'b0; DIR = 1'b0; data_in = 8'h00; #1;
    checks++; if (data_oe !== 1'b0) $display("FAIL rd_back_turn got=%b exp=0", data_oe); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (data_oe !== 1'b1 || busy !== 1'b0 || reg_rdata !== 8'h24)
      $display("FAIL rd_after got=oe%b busy%b rdata%h exp=1/0/24", data_oe, busy, reg_rdata); else passes++;
  endtask

  task automatic test_ack();
    @(negedge CLKOUT); pkt_req = 1'b1; pkt_pid = 4'h2; pkt_nodata = 1'b1; pkt_valid = 1'b1;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'h42 || pkt_ready !== 1'b0) $display("FAIL ack_cmd got=%h/%b exp=42/0", data_out, pkt_ready); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (pkt_ready !== 1'b0) $display("FAIL ack_ready got=%b exp=0", pkt_ready); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (STP !== 1'b1 || pkt_done !== 1'b1 || pkt_ready !== 1'b0)
      $display("FAIL ack_stop got=stp%b done%b rdy%b exp=1/1/0", STP, pkt_done, pkt_ready); else passes++;
    pkt_req = 1'b0; pkt_valid = 1'b0;
    @(negedge CLKOUT); #1;
    checks++; if (busy !== 1'b0 || pkt_done !== 1'b0) $display("FAIL ack_after got=busy%b done%b exp=0/0", busy, pkt_done); else passes++;
  endtask

  task automatic test_data1_packet();
    logic [7:0] bytes [18];
    int idx = 0;
    int ready_cnt = 0;
    logic exp_ready;
    for (int i = 0; i < 18; i++) bytes[i] = 8'(8'h20 + i);
    bytes[0] = 8'h12; bytes[1] = 8'h01; bytes[2] = 8'h10; bytes[3] = 8'h01;
    @(negedge CLKOUT); pkt_req = 1'b1; pkt_pid = 4'hB; pkt_nodata = 1'b0;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'h4B) $display("FAIL d1_cmd got=%h exp=4b", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLKOUT);
      pkt_valid = 1'b1; pkt_data = bytes[idx]; pkt_last = (idx == 17); NXT = ((k % 3) != 2);
      exp_ready = NXT;
      #1;
      checks++; if (data_out !== bytes[idx] || STP !== 1'b0)
        $display("FAIL d1_byte%0d got=%h stp%b exp=%h stp0", idx, data_out, STP, bytes[idx]); else passes++;
      checks++; if (pkt_ready !== exp_ready) $display("FAIL d1_ready%0d got=%b exp=%b", idx, pkt_ready, exp_ready); else passes++;
      if (pkt_ready === 1'b1) begin
        ready_cnt++;
        idx++;
      end
      if (idx == 18) break;
    end
    @(negedge CLKOUT); NXT = 1'b0; pkt_valid = 1'b0; pkt_last = 1'b0; #1;
    checks++; if (STP !== 1'b1 || pkt_done !== 1'b1 || pkt_ready !== 1'b0)
      $display("FAIL d1_stop got=stp%b done%b rdy%b exp=1/1/0", STP, pkt_done, pkt_ready); else passes++;
    checks++; if (ready_cnt != 18) $display("FAIL d1_ready_count got=%0d exp=18", ready_cnt); else passes++;
    pkt_req = 1'b0;
    @(negedge CLKOUT);
  endtask

  task automatic test_interrupt_pkt();
    @(negedge CLKOUT); pkt_req = 1'b1; pkt_pid = 4'h3; pkt_nodata = 1'b0;
    pkt_valid = 1'b1; pkt_data = 8'hAA; pkt_last = 1'b0;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h43) $display("FAIL ipk_cmd got=%h exp=43", data_out); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'hAA || pkt_ready !== 1'b1) $display("FAIL ipk_byte got=%h/%b exp=aa/1", data_out, pkt_ready); else passes++;
    @(negedge CLKOUT); DIR = 1'b1; #1;
    checks++; if (data_oe !== 1'b0 || pkt_ready !== 1'b0) $display("FAIL ipk_dir got=oe%b rdy%b exp=0/0", data_oe, pkt_ready); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; data_in = 8'h5D; #1;
    checks++; if (pkt_abort !== 1'b1 || STP !== 1'b0) $display("FAIL ipk_abort got=abort%b stp%b exp=1/0", pkt_abort, STP); else passes++;
    pkt_req = 1'b0; pkt_valid = 1'b0;
    @(negedge CLKOUT); #1;
    checks++; if (rxcmd !== 8'h5D || rxcmd_valid !== 1'b1 || pkt_abort !== 1'b0)
      $display("FAIL ipk_rxcmd got=%h v%b abort%b exp=5d/1/0", rxcmd, rxcmd_valid, pkt_abort); else passes++;
    DIR = 1'b0; data_in = 8'h00; #1;
    checks++; if (data_oe !== 1'b0) $display("FAIL ipk_turn got=%b exp=0", data_oe); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (busy !== 1'b0 || data_oe !== 1'b1 || rxcmd_valid !== 1'b0)
      $display("FAIL ipk_after got=busy%b oe%b v%b exp=0/1/0", busy, data_oe, rxcmd_valid); else passes++;
  endtask

  task automatic test_interrupt_reg();
    @(negedge CLKOUT); reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h04; reg_wdata = 8'h45;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h84) $display("FAIL irg_cmd got=%h exp=84", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; DIR = 1'b1; #1;
    checks++; if (data_oe !== 1'b0) $display("FAIL irg_dir got=%b exp=0", data_oe); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (busy !== 1'b1 || reg_done !== 1'b0 || reg_abort !== 1'b0)
      $display("FAIL irg_wait got=busy%b done%b abort%b exp=1/0/0", busy, reg_done, reg_abort); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; DIR = 1'b0;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h84 || data_oe !== 1'b1) $display("FAIL irg_retry got=%h oe%b exp=84/1", data_out, data_oe); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'h45) $display("FAIL irg_wdata got=%h exp=45", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (reg_done !== 1'b1 || STP !== 1'b1) $display("FAIL irg_done got=done%b stp%b exp=1/1", reg_done, STP); else passes++;
    reg_req = 1'b0;
    @(negedge CLKOUT);
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit seen = 1'b0;
    @(negedge CLKOUT); reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h0A; reg_wdata = 8'h00; NXT = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge CLKOUT); #1;
      if (reg_abort === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cnt++;
    end
    checks++; if (seen !== 1'b1) $display("FAIL to_seen got=%b exp=1", seen); else passes++;
    checks++; if (cnt != 1023) $display("FAIL to_cycles got=%0d exp=1023", cnt); else passes++;
    checks++; if (busy !== 1'b0 || STP !== 1'b0 || reg_done !== 1'b0)
      $display("FAIL to_state got=busy%b stp%b done%b exp=0/0/0", busy, STP, reg_done); else passes++;
    reg_req = 1'b0;
    @(negedge CLKOUT);
  endtask

  task automatic test_underrun();
    @(negedge CLKOUT); pkt_req = 1'b1; pkt_pid = 4'hB; pkt_nodata = 1'b0;
    pkt_valid = 1'b1; pkt_data = 8'h11; pkt_last = 1'b0;
    @(negedge CLKOUT); NXT = 1'b1;
    @(negedge CLKOUT); #1;
    checks++; if (pkt_ready !== 1'b1) $display("FAIL ur_first got=%b exp=1", pkt_ready); else passes++;
    @(negedge CLKOUT); pkt_valid = 1'b0; #1;
    checks++; if (pkt_ready !== 1'b0) $display("FAIL ur_ready got=%b exp=0", pkt_ready); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (STP !== 1'b1 || pkt_abort !== 1'b1 || pkt_done !== 1'b0 || data_out !== 8'h00)
      $display("FAIL ur_stop got=stp%b abort%b done%b data%h exp=1/1/0/00", STP, pkt_abort, pkt_done, data_out); else passes++;
    pkt_req = 1'b0;
    @(negedge CLKOUT); #1;
    checks++; if (busy !== 1'b0 || STP !== 1'b0) $display("FAIL ur_after got=busy%b stp%b exp=0/0", busy, STP); else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge CLKOUT); pkt_req = 1'b1; pkt_pid = 4'hB; pkt_nodata = 1'b0;
    pkt_valid = 1'b1; pkt_data = 8'h11; pkt_last = 1'b0;
    @(negedge CLKOUT); NXT = 1'b1;
    @(negedge CLKOUT);
    @(negedge CLKOUT); RESET = 1'b1; pkt_last = 1'b1;
    @(negedge CLKOUT); RESET = 1'b0; pkt_req = 1'b0; pkt_valid = 1'b0; pkt_last = 1'b0; NXT = 1'b0; #1;
    checks++; if (busy !== 1'b0 || STP !== 1'b0 || data_out !== 8'h00)
      $display("FAIL rm_state got=busy%b stp%b data%h exp=0/0/00", busy, STP, data_out); else passes++;
    checks++; if (pkt_done !== 1'b0 || pkt_abort !== 1'b0) $display("FAIL rm_pulses got=done%b abort%b exp=0/0", pkt_done, pkt_abort); else passes++;
    checks++; if (reg_rdata !== 8'h00 || rxcmd !== 8'h00) $display("FAIL rm_regs got=%h/%h exp=00/00", reg_rdata, rxcmd); else passes++;
    @(negedge CLKOUT);
  endtask

  task automatic test_back_to_back();
    @(negedge CLKOUT); RESET = 1'b1;
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h04; reg_wdata = 8'h45;
    pkt_req = 1'b1; pkt_pid = 4'h2; pkt_nodata = 1'b1;
    @(negedge CLKOUT); RESET = 1'b0;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h84) $display("FAIL tie1_reg got=%h exp=84", data_out); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (data_out !== 8'h45) $display("FAIL tie1_wdata got=%h exp=45", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (reg_done !== 1'b1) $display("FAIL tie1_done got=%b exp=1", reg_done); else passes++;
    @(negedge CLKOUT); #1;
    checks++; if (busy !== 1'b0) $display("FAIL tie_gap got=%b exp=0", busy); else passes++;
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h42) $display("FAIL tie2_pkt got=%h exp=42", data_out); else passes++;
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (pkt_done !== 1'b1) $display("FAIL tie2_done got=%b exp=1", pkt_done); else passes++;
    pkt_req = 1'b0;
    @(negedge CLKOUT);
    @(negedge CLKOUT); NXT = 1'b1; #1;
    checks++; if (data_out !== 8'h84) $display("FAIL waiting_reg got=%h exp=84", data_out); else passes++;
    @(negedge CLKOUT);
    @(negedge CLKOUT); NXT = 1'b0; #1;
    checks++; if (reg_done !== 1'b1) $display("FAIL waiting_done got=%b exp=1", reg_done); else passes++;
    reg_req = 1'b0;
    @(negedge CLKOUT);
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_reg_read();
    test_ack();
    test_data1_packet();
    test_interrupt_pkt();
    test_interrupt_reg();
    test_timeout();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/ulpi_link_arbiter.md
Name: ulpi_link_arbiter

Overview:
- Owns the link side of the ULPI bus, clocked by the PHY's 60 MHz CLKOUT.
- Shares the transmit path between two requesters:
  - a register port, used for PHY configuration (OTG_CTRL, FUNC_CTRL writes; ID reads);
  - a packet port, used for USB handshakes and data packets (ACK/NAK, DATA0/DATA1).
- Sequences TXCMD, data and STP; tracks DIR/NXT turnaround; forwards RXCMD bytes.
- The top level ties the bidirectional bus as data = data_oe ? data_out : high-Z.

Parameters:
- NXT_TIMEOUT, 1023: CLKOUT cycles to wait for NXT on a TXCMD before aborting.
- RR_RESET_LAST, 1: reset value of last_grant (1 = packet), so the register port wins the first tie.

Ports:
- CLKOUT in 1: ULPI clock; all logic is on its rising edge.
- RESET in 1: synchronous, active-high reset.
- DIR in 1: ULPI direction; 1 = PHY drives the bus.
- NXT in 1: ULPI next/throttle.
- data_in in 8: ULPI bus sampled value.
- data_out out 8: link drive value.
- data_oe out 1: link drive enable.
- STP out 1: ULPI stop.
- reg_req in 1: register access request; held until reg_done or reg_abort.
- reg_we in 1: 1 = write, 0 = read.
- reg_addr in 6: register address.
- reg_wdata in 8: write data.
- reg_done out 1: one-cycle pulse when the access completes.
- reg_rdata out 8: read data; valid with reg_done for reads, held afterwards.
- pkt_req in 1: packet request; held until pkt_done or pkt_abort.
- pkt_pid in 4: PID, sampled at grant.
- pkt_nodata in 1: 1 = PID-only packet; sampled at grant.
- pkt_data in 8: payload byte.
- pkt_valid in 1: payload byte valid.
- pkt_last in 1: marks the final payload byte.
- pkt_ready out 1: payload byte consumed this cycle.
- pkt_done out 1: one-cycle pulse, packet sent.
- pkt_abort out 1: one-cycle pulse, packet terminated.
- reg_abort out 1: one-cycle pulse, register access terminated by timeout.
- rxcmd out 8: last RXCMD byte received.
- rxcmd_valid out 1: one-cycle pulse when a new RXCMD is captured.
- busy out 1: 1 whenever state is not IDLE.

Behaviour:
- Reset (RESET=1 at edge):
  - state=IDLE, data_out=00, STP=0, all pulses 0, reg_rdata=00, rxcmd=00, last_grant=RR_RESET_LAST, timeout counter=0.
  - Reset mid-transfer drops the bus immediately. No STP is issued. No done/abort pulse is issued.
- data_oe:
  - 0 when DIR=1.
  - 0 in the first cycle after DIR falls (turnaround).
  - 1 otherwise.
- data_out is 00 (NOOP) whenever no command or data is being driven.
- RXCMD capture: DIR=1, NXT=0 and not the first cycle after DIR rose → rxcmd<=data_in, rxcmd_valid=1.
- IDLE:
  - Grant only when DIR=0 and not in the turnaround cycle.
  - If only one requester is active, it wins.
  - If both are active, the port opposite last_grant wins; last_grant updates at every grant.
  - On grant: latch command fields, clear the timeout counter, go to TXCMD.
- TXCMD: drive the command byte.
  - Register write: 10 & reg_addr. Register read: 11 & reg_addr. Packet: 0100 & pkt_pid.
  - Hold the byte until NXT=1.
  - Next state on NXT=1: write → REG_WDATA; read → RD_TURN; packet with nodata=1 → STOP; packet with nodata=0 → PKT_DATA.
  - Timeout counter reaches NXT_TIMEOUT → drop to IDLE, pulse the granted port's abort.
- REG_WDATA: drive reg_wdata; on NXT=1 → STOP.
- STOP:
  - Drive 00 with STP=1 for exactly one cycle.
  - Pulse reg_done or pkt_done in that same cycle, then go to IDLE.
- RD_TURN: the cycle DIR is seen rising is turnaround; data_oe=0; → RD_DATA.
- RD_DATA: reg_rdata<=data_in, pulse reg_done, → WAIT_DIR_LOW.
- PKT_DATA:
  - Drive pkt_data. pkt_ready = NXT & pkt_valid & !DIR.
  - Consumed byte with pkt_last=1 → STOP.
  - pkt_valid=0 while NXT=1 (underrun): drive 00, STP=1 for one cycle, pulse pkt_abort, → IDLE.
- PHY interrupt (DIR rising while in TXCMD, REG_WDATA or PKT_DATA; read turnaround is excluded):
  - Release the bus; keep the grant.
  - Register access: wait in WAIT_DIR_LOW, then retry from TXCMD after turnaround.
  - Packet: pulse pkt_abort, → WAIT_DIR_LOW, then → IDLE.
- WAIT_DIR_LOW: stay until DIR=0; then skip one turnaround cycle.
- Simultaneous events:
  - A request that arrives while busy waits; it is not dropped.
  - A requester that deasserts before its grant is not granted.

Test Plan:
- Register write OTG_CTRL (reg_addr=0A, wdata=00):
  - Bus shows 8A until NXT, then 00 until NXT, then STP=1 for one cycle.
  - reg_done coincides with STP; busy is back to 0 on the next cycle.
- Register read vendor ID low (addr 00):
  - 0xC0 is held until NXT; the PHY raises DIR; data_oe=0 for the turnaround cycle.
  - The PHY drives 24 → reg_rdata=24 with reg_done.
- PID-only ACK (pid=2, nodata=1): data_out=42 until NXT, then STP for one cycle, then pkt_done; pkt_ready never asserts.
- 18-byte DATA1 packet (pid=B, bytes 12 01 10 01 …):
  - Header 4B is followed by each byte advancing only on NXT.
  - Exactly 18 pkt_ready pulses; STP after the last byte.
- Both ports requesting at reset: register is granted first, then packet. A second tie grants the port that lost the previous tie.
- DIR raised mid-packet: pkt_abort pulses and data_oe drops. Separately, DIR raised mid-register-write: the access is retried after DIR falls and reg_done is asserted.
- NXT held low: reg_abort after exactly 1023 cycles. Separately, pkt_valid dropped mid-packet: STP plus pkt_abort.
- RESET asserted mid-packet: outputs return to reset values on the next edge, with no STP, pkt_done or pkt_abort pulse.
